// File: rtl/simplez_loader_if.sv
// Byte-in / RAM-write bundle between the serial receiver, the loader and program RAM.
// Latency: none, signal grouping only.
// Backpressure: none; rx_rcv is a strobe and mem_we is a one-cycle write pulse.
// Ports: rx_data/rx_rcv (receiver -> loader), mem_addr/mem_din/mem_we (loader -> RAM).
// The master modport is the loader side; the slave modport is the receiver/RAM side.
interface simplez_loader_if #(
    parameter int AW = 9
);
    logic [7:0]    rx_data;
    logic          rx_rcv;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_din;
    logic          mem_we;

    modport master (
        input  rx_data,
        input  rx_rcv,
        output mem_addr,
        output mem_din,
        output mem_we
    );

    modport slave (
        output rx_data,
        output rx_rcv,
        input  mem_addr,
        input  mem_din,
        input  mem_we
    );
endinterface

// File: rtl/simplez_loader.sv
// Frame-based boot loader: parses SYNC, N, N x (lo,hi) words into 12-bit RAM writes, then releases the CPU.
// Latency: RAM write is issued the cycle after the hi byte; status outputs follow the state register.
// Backpressure: none; bytes must arrive at least 2 cycles apart, an inter-byte gap of TIMEOUT cycles aborts the frame.
// Ports: clk, rstn (async, active-low); bus (master modport: rx_data/rx_rcv in, mem_addr/mem_din/mem_we out);
//        cpu_rstn (CPU held in reset until a frame is accepted), busy (frame in progress), error (frame rejected).
// Build option: define LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module simplez_loader #(
    parameter int          AW      = 9,
    parameter int unsigned TIMEOUT = 1200000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic                clk,
    input  logic                rstn,
    simplez_loader_if.master    bus,
    output logic                cpu_rstn,
    output logic                busy,
    output logic                error
);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        LO   = 3'd2,
        HI   = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t        state_q, state_d;
    logic [7:0]    word_cnt_q, word_cnt_d;
    logic [AW-1:0] addr_cnt_q, addr_cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [11:0]   mem_din_q, mem_din_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_rstn_q, cpu_rstn_d;
    logic          busy_q, busy_d;
    logic          error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic in_frame;
    assign in_frame = (state_q == LEN) || (state_q == LO) || (state_q == HI) || (state_q == CSUM);

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        addr_cnt_d = addr_cnt_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        // The idle counter only matters inside a frame; parking it at zero elsewhere
        // means every frame starts with a full timeout budget.
        idle_d = (bus.rx_rcv || !in_frame) ? '0 : idle_q + IW'(1);

        case (state_q)
            IDLE: begin
                if (bus.rx_rcv && bus.rx_data == SYNC) state_d = LEN;
            end
            LEN: begin
                if (bus.rx_rcv) begin
                    word_cnt_d = bus.rx_data;
                    addr_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                    state_d    = (bus.rx_data != 8'h00) ? LO : END_STATE;
                end
            end
            LO: begin
                if (bus.rx_rcv) begin
                    mem_din_d[7:0] = bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
                    csum_d         = csum_q + bus.rx_data;
`endif
                    state_d        = HI;
                end
            end
            HI: begin
                if (bus.rx_rcv) begin
                    // Write is registered: it appears on the bus the cycle after the hi byte,
                    // carrying the pre-increment address.
                    mem_din_d[11:8] = bus.rx_data[3:0];
                    mem_we_d        = 1'b1;
                    mem_addr_d      = addr_cnt_q;
                    addr_cnt_d      = addr_cnt_q + AW'(1);
                    word_cnt_d      = word_cnt_q - 8'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d          = csum_q + bus.rx_data;
`endif
                    state_d         = (word_cnt_q == 8'd1) ? END_STATE : LO;
                end
            end
            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (bus.rx_rcv) state_d = (bus.rx_data == csum_q) ? DONE : ERR;
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                // Serial line now belongs to the CPU; only rstn leaves this state.
                state_d = DONE;
            end
            ERR: begin
                if (bus.rx_rcv && bus.rx_data == SYNC) state_d = LEN;
            end
            default: state_d = IDLE;
        endcase

        if (in_frame && !bus.rx_rcv && idle_q == IW'(TIMEOUT - 1)) state_d = ERR;

        cpu_rstn_d = (state_d == DONE);
        busy_d     = (state_d == LEN) || (state_d == LO) || (state_d == HI) || (state_d == CSUM);
        error_d    = (state_d == ERR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            addr_cnt_q <= '0;
            idle_q     <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_we_q   <= 1'b0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            idle_q     <= idle_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_we_q   <= mem_we_d;
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.mem_we   = mem_we_q;
    assign cpu_rstn     = cpu_rstn_q;
    assign busy         = busy_q;
    assign error        = error_q;
endmodule

// File: tb/tb_simplez_loader.sv
// Directed bench for simplez_loader: frame load, bad checksum, leading junk, timeout, empty frame, mid-frame reset.
// Latency: writes are captured on the falling edge after they appear.
// Backpressure: none; bytes are sent one strobe every 3 cycles.
module tb_simplez_loader;
    localparam int          AW      = 9;
    localparam int unsigned TIMEOUT = 16;

    logic clk;
    logic rstn;
    logic cpu_rstn, busy, error;

    simplez_loader_if #(.AW(AW)) bus ();

    simplez_loader #(.AW(AW), .TIMEOUT(TIMEOUT), .SYNC(8'hA5)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .cpu_rstn (cpu_rstn),
        .busy     (busy),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Write monitor, sampled away from the active edge.
    int            wr_cnt = 0;
    logic [AW-1:0] wr_addr [64];
    logic [11:0]   wr_dat  [64];
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr[wr_cnt % 64] <= bus.mem_addr;
            wr_dat[wr_cnt % 64]  <= bus.mem_din;
            wr_cnt               <= wr_cnt + 1;
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data = b;
        bus.rx_rcv  = 1'b1;
        @(posedge clk); #1;
        bus.rx_rcv  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.rx_rcv  = 1'b0;
        bus.rx_data = 8'h00;
        rstn = 1'b0;
        wait_cycles(3);
        rstn = 1'b1;
        wait_cycles(2);
    endtask

    task automatic send_frame_a(input logic [7:0] csum);
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hFF); send_byte(8'h07);
`ifdef LOADER_CHECKSUM_EN
        send_byte(csum);
`else
        if (csum == 8'h4C) wait_cycles(1);
`endif
        wait_cycles(2);
    endtask

    task automatic test_reset();
        bus.rx_rcv = 1'b0; bus.rx_data = 8'h00;
        rstn = 1'b0;
        #12;
        checks++; if (cpu_rstn !== 1'b0) begin errors++; $display("FAIL reset_cpu_rstn: got %b want 0", cpu_rstn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 9'h000) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", bus.mem_addr); end
        checks++; if (bus.mem_din !== 12'h000) begin errors++; $display("FAIL reset_mem_din: got %h want 000", bus.mem_din); end
        wait_cycles(2);
        rstn = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_frame();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_after_sync: got %b want 1", busy); end
        send_byte(8'h02); send_byte(8'h34); send_byte(8'h12); send_byte(8'hFF); send_byte(8'h07);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h4C);
`endif
        wait_cycles(2);
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL frame_writes: got %0d want 2", wr_cnt - base); end
        checks++; if (wr_addr[base % 64] !== 9'h000 || wr_dat[base % 64] !== 12'h234) begin errors++; $display("FAIL frame_w0: got %h@%h want 234@000", wr_dat[base % 64], wr_addr[base % 64]); end
        checks++; if (wr_addr[(base + 1) % 64] !== 9'h001 || wr_dat[(base + 1) % 64] !== 12'h7FF) begin errors++; $display("FAIL frame_w1: got %h@%h want 7ff@001", wr_dat[(base + 1) % 64], wr_addr[(base + 1) % 64]); end
        checks++; if (cpu_rstn !== 1'b1) begin errors++; $display("FAIL frame_cpu_rstn: got %b want 1", cpu_rstn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_end: got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL frame_error: got %b want 0", error); end
    endtask

    task automatic test_bad_checksum();
`ifdef LOADER_CHECKSUM_EN
        int base;
        do_reset();
        base = wr_cnt;
        send_frame_a(8'h00);
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL badcs_writes: got %0d want 2", wr_cnt - base); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL badcs_error: got %b want 1", error); end
        checks++; if (cpu_rstn !== 1'b0) begin errors++; $display("FAIL badcs_cpu_rstn: got %b want 0", cpu_rstn); end
        send_byte(8'hA5);
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL badcs_resync: got error=%b busy=%b want 0 1", error, busy); end
        send_byte(8'h02); send_byte(8'h34); send_byte(8'h12); send_byte(8'hFF); send_byte(8'h07); send_byte(8'h4C);
        wait_cycles(2);
        checks++; if (cpu_rstn !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL badcs_recover: got cpu_rstn=%b error=%b want 1 0", cpu_rstn, error); end
`endif
    endtask

    task automatic test_leading_bytes();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'hFF);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lead_busy: got %b want 0", busy); end
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'hF0);
        send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h03); send_byte(8'hA2);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h99);
`endif
        wait_cycles(2);
        checks++; if (wr_cnt - base !== 3) begin errors++; $display("FAIL lead_writes: got %0d want 3", wr_cnt - base); end
        checks++; if (wr_addr[base % 64] !== 9'h000 || wr_dat[base % 64] !== 12'h001) begin errors++; $display("FAIL lead_w0: got %h@%h want 001@000", wr_dat[base % 64], wr_addr[base % 64]); end
        checks++; if (wr_addr[(base + 1) % 64] !== 9'h001 || wr_dat[(base + 1) % 64] !== 12'h102) begin errors++; $display("FAIL lead_w1: got %h@%h want 102@001", wr_dat[(base + 1) % 64], wr_addr[(base + 1) % 64]); end
        checks++; if (wr_addr[(base + 2) % 64] !== 9'h002 || wr_dat[(base + 2) % 64] !== 12'h203) begin errors++; $display("FAIL lead_w2: got %h@%h want 203@002", wr_dat[(base + 2) % 64], wr_addr[(base + 2) % 64]); end
        checks++; if (cpu_rstn !== 1'b1) begin errors++; $display("FAIL lead_cpu_rstn: got %b want 1", cpu_rstn); end
    endtask

    task automatic test_timeout();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h34);
        checks++; if (busy !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL tmo_before: got busy=%b error=%b want 1 0", busy, error); end
        wait_cycles(TIMEOUT + 1);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b want 1", error); end
        checks++; if (busy !== 1'b0 || cpu_rstn !== 1'b0) begin errors++; $display("FAIL tmo_status: got busy=%b cpu_rstn=%b want 0 0", busy, cpu_rstn); end
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL tmo_writes: got %0d want 0", wr_cnt - base); end
    endtask

    task automatic test_empty_frame();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        wait_cycles(2);
        checks++; if (cpu_rstn !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL empty_done: got cpu_rstn=%b busy=%b want 1 0", cpu_rstn, busy); end
        send_byte(8'hA5);
        wait_cycles(2);
        checks++; if (cpu_rstn !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL empty_ignore_sync: got cpu_rstn=%b busy=%b want 1 0", cpu_rstn, busy); end
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL empty_writes: got %0d want 0", wr_cnt - base); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        do_reset();
        base = wr_cnt;
        send_byte(8'hA5); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hFF);
        // Hi byte of the second word arrives together with the reset pulse.
        @(posedge clk); #1;
        bus.rx_data = 8'h07;
        bus.rx_rcv  = 1'b1;
        rstn        = 1'b0;
        @(posedge clk); #1;
        bus.rx_rcv  = 1'b0;
        checks++; if (cpu_rstn !== 1'b0 || busy !== 1'b0 || bus.mem_addr !== 9'h000) begin errors++; $display("FAIL midrst_state: got cpu_rstn=%b busy=%b addr=%h want 0 0 000", cpu_rstn, busy, bus.mem_addr); end
        rstn = 1'b1;
        wait_cycles(6);
        checks++; if (wr_cnt - base !== 1) begin errors++; $display("FAIL midrst_writes: got %0d want 1", wr_cnt - base); end
        checks++; if (cpu_rstn !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL midrst_idle: got cpu_rstn=%b busy=%b error=%b want 0 0 0", cpu_rstn, busy, error); end
    endtask

    initial begin
        rstn = 1'b0;
        bus.rx_rcv = 1'b0;
        bus.rx_data = 8'h00;
        test_reset();
        test_frame();
        test_bad_checksum();
        test_leading_bytes();
        test_timeout();
        test_empty_frame();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
